// File: rtl/axis_gate_pkg.sv
// Shared types and width helpers for the packet-aware multi-lane AXI-Stream gate.
package axis_gate_pkg;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    WAIT_EOP = 2'd1,
    SHUT     = 2'd2,
    RESYNC   = 2'd3
  } lane_state_t;

  // Bytes per beat for a tdata width that is a multiple of 8.
  function automatic int unsigned keep_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Bits needed to count 0 .. cycles-1; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/axis_gate_lane.sv
// One gated AXI-Stream lane: packet tracking, shutdown FSM, timeout timer,
// discard counter and zero-latency output mux.
module axis_gate_lane
  import axis_gate_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 1,
  parameter int unsigned C_AXIS_HAS_TLAST   = 1,
  parameter int unsigned C_DRAIN_MODE       = 0,
  parameter int unsigned C_TIMEOUT_CYCLES   = 0,
  parameter int unsigned C_CNT_WIDTH        = 32,
  localparam int unsigned KEEP_W            = keep_width(C_AXIS_TDATA_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          shutdown_req,
  output logic                          shutdown_ack,
  output logic                          timeout_flag,
  input  logic                          cnt_clear,
  output logic [C_CNT_WIDTH-1:0]        discard_cnt,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_W-1:0]             s_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0] s_tuser,
  input  logic                          s_tlast,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_W-1:0]             m_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0] m_tuser,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready
);

  localparam int unsigned TMR_W      = timer_width(C_TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN = (C_TIMEOUT_CYCLES > 0);
  localparam bit          HAS_TLAST  = (C_AXIS_HAS_TLAST != 0);
  localparam bit          DRAIN      = (C_DRAIN_MODE != 0);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(TIMEOUT_EN ? C_TIMEOUT_CYCLES - 1 : 0);

  lane_state_t            state_q, state_d;
  logic                   in_pkt_q, in_pkt_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   flag_q, flag_d;
  logic                   ack_q;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   gate_open;
  logic                   acc;
  logic                   eop;

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PASS;
      in_pkt_q <= 1'b0;
      timer_q  <= '0;
      flag_q   <= 1'b0;
      ack_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
      timer_q  <= timer_d;
      flag_q   <= flag_d;
      ack_q    <= (state_q == SHUT);
      cnt_q    <= cnt_d;
    end
  end

  // Output mux, handshake, and next-state logic.
  always_comb begin
    state_d   = state_q;
    gate_open = 1'b0;
    s_tready  = 1'b0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tuser   = '0;
    m_tlast   = 1'b0;
    m_tvalid  = 1'b0;
    flag_d    = flag_q;

    case (state_q)
      PASS, WAIT_EOP: begin
        gate_open = 1'b1;
        s_tready  = m_tready;
      end
      SHUT:    s_tready = DRAIN;
      RESYNC:  s_tready = 1'b1;
      default: s_tready = 1'b0;
    endcase

    if (gate_open) begin
      m_tdata  = s_tdata;
      m_tkeep  = s_tkeep;
      m_tuser  = s_tuser;
      m_tlast  = s_tlast;
      m_tvalid = s_tvalid;
    end

    acc      = s_tvalid & s_tready;
    eop      = HAS_TLAST & acc & s_tlast;
    in_pkt_d = HAS_TLAST ? (acc ? ~s_tlast : in_pkt_q) : 1'b0;
    // Timer is zero on every entry to WAIT_EOP because it is held clear elsewhere.
    timer_d  = (state_q == WAIT_EOP) ? timer_q + TMR_W'(1) : '0;

    case (state_q)
      PASS: begin
        if (shutdown_req) state_d = in_pkt_d ? WAIT_EOP : SHUT;
      end
      WAIT_EOP: begin
        if (!shutdown_req) begin
          state_d = PASS;
        end else if (eop) begin
          state_d = SHUT;
        end else if (TIMEOUT_EN && (timer_q == TMR_LAST)) begin
          state_d = SHUT;
          flag_d  = 1'b1;
        end
      end
      SHUT: begin
        if (!shutdown_req) state_d = in_pkt_d ? RESYNC : PASS;
      end
      RESYNC: begin
        if (shutdown_req) state_d = SHUT;
        else if (eop)     state_d = PASS;
      end
      default: state_d = PASS;
    endcase

    if (!shutdown_req) flag_d = 1'b0;

    // Clear wins over a same-cycle discard; the count saturates at all-ones.
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (acc && !gate_open && !(&cnt_q)) begin
      cnt_d = cnt_q + C_CNT_WIDTH'(1);
    end
  end

  assign shutdown_ack = ack_q;
  assign timeout_flag = flag_q;
  assign discard_cnt  = cnt_q;

endmodule

// File: rtl/axis_gate_mc.sv
// Multi-lane packet-aware AXI-Stream gate; slices the flat buses into
// independent axis_gate_lane instances.
module axis_gate_mc
  import axis_gate_pkg::*;
#(
  parameter int unsigned C_NUM_CHANNELS     = 4,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 1,
  parameter int unsigned C_AXIS_HAS_TLAST   = 1,
  parameter int unsigned C_DRAIN_MODE       = 0,
  parameter int unsigned C_TIMEOUT_CYCLES   = 0,
  parameter int unsigned C_CNT_WIDTH        = 32,
  localparam int unsigned KEEP_W            = keep_width(C_AXIS_TDATA_WIDTH)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [C_NUM_CHANNELS-1:0]                    shutdown_req,
  output logic [C_NUM_CHANNELS-1:0]                    shutdown_ack,
  output logic [C_NUM_CHANNELS-1:0]                    timeout_flag,
  input  logic                                         cnt_clear,
  output logic [C_NUM_CHANNELS*C_CNT_WIDTH-1:0]        discard_cnt,
  input  logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_CHANNELS*KEEP_W-1:0]             s_axis_tkeep,
  input  logic [C_NUM_CHANNELS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [C_NUM_CHANNELS-1:0]                    s_axis_tlast,
  input  logic [C_NUM_CHANNELS-1:0]                    s_axis_tvalid,
  output logic [C_NUM_CHANNELS-1:0]                    s_axis_tready,
  output logic [C_NUM_CHANNELS*C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_NUM_CHANNELS*KEEP_W-1:0]             m_axis_tkeep,
  output logic [C_NUM_CHANNELS*C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic [C_NUM_CHANNELS-1:0]                    m_axis_tlast,
  output logic [C_NUM_CHANNELS-1:0]                    m_axis_tvalid,
  input  logic [C_NUM_CHANNELS-1:0]                    m_axis_tready
);

  localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
  localparam int unsigned UW = C_AXIS_TUSER_WIDTH;
  localparam int unsigned CW = C_CNT_WIDTH;

  // Lane i owns slice i of every flat bus.
  for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_lane
    axis_gate_lane #(
      .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
      .C_AXIS_TUSER_WIDTH (C_AXIS_TUSER_WIDTH),
      .C_AXIS_HAS_TLAST   (C_AXIS_HAS_TLAST),
      .C_DRAIN_MODE       (C_DRAIN_MODE),
      .C_TIMEOUT_CYCLES   (C_TIMEOUT_CYCLES),
      .C_CNT_WIDTH        (C_CNT_WIDTH)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .shutdown_req (shutdown_req[i]),
      .shutdown_ack (shutdown_ack[i]),
      .timeout_flag (timeout_flag[i]),
      .cnt_clear    (cnt_clear),
      .discard_cnt  (discard_cnt[i*CW +: CW]),
      .s_tdata      (s_axis_tdata[i*DW +: DW]),
      .s_tkeep      (s_axis_tkeep[i*KEEP_W +: KEEP_W]),
      .s_tuser      (s_axis_tuser[i*UW +: UW]),
      .s_tlast      (s_axis_tlast[i]),
      .s_tvalid     (s_axis_tvalid[i]),
      .s_tready     (s_axis_tready[i]),
      .m_tdata      (m_axis_tdata[i*DW +: DW]),
      .m_tkeep      (m_axis_tkeep[i*KEEP_W +: KEEP_W]),
      .m_tuser      (m_axis_tuser[i*UW +: UW]),
      .m_tlast      (m_axis_tlast[i]),
      .m_tvalid     (m_axis_tvalid[i]),
      .m_tready     (m_axis_tready[i])
    );
  end

endmodule

// File: tb/tb_axis_gate_mc.sv
// Randomized bench for axis_gate_mc: two configurations share one stimulus
// stream and are compared every cycle against a per-lane behavioural model.
module tb_axis_gate_mc;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned KW    = 2;
  localparam int unsigned UW    = 1;
  localparam int unsigned CW_A  = 32;
  localparam int unsigned CW_B  = 4;
  localparam int unsigned TMO_B = 8;
  localparam int unsigned NCYC  = 2000;

  localparam int G_PASS = 0, G_WAIT = 1, G_SHUT = 2, G_RESYNC = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      req;
  logic                cnt_clear;
  logic [NCH*DW-1:0]   s_tdata;
  logic [NCH*KW-1:0]   s_tkeep;
  logic [NCH*UW-1:0]   s_tuser;
  logic [NCH-1:0]      s_tlast, s_tvalid, m_tready;

  logic [NCH-1:0]      s_tready_a, ack_a, flag_a, m_tlast_a, m_tvalid_a;
  logic [NCH*CW_A-1:0] cnt_a;
  logic [NCH*DW-1:0]   m_tdata_a;
  logic [NCH*KW-1:0]   m_tkeep_a;
  logic [NCH*UW-1:0]   m_tuser_a;

  logic [NCH-1:0]      s_tready_b, ack_b, flag_b, m_tlast_b, m_tvalid_b;
  logic [NCH*CW_B-1:0] cnt_b;
  logic [NCH*DW-1:0]   m_tdata_b;
  logic [NCH*KW-1:0]   m_tkeep_b;
  logic [NCH*UW-1:0]   m_tuser_b;

  always #5 clk = ~clk;

  // Configuration A: hold-off shutdown, no timeout, wide counters.
  axis_gate_mc #(
    .C_NUM_CHANNELS(NCH), .C_AXIS_TDATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW),
    .C_AXIS_HAS_TLAST(1), .C_DRAIN_MODE(0), .C_TIMEOUT_CYCLES(0), .C_CNT_WIDTH(CW_A)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .shutdown_req(req), .shutdown_ack(ack_a),
    .timeout_flag(flag_a), .cnt_clear(cnt_clear), .discard_cnt(cnt_a),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a),
    .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tuser(m_tuser_a),
    .m_axis_tlast(m_tlast_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready)
  );

  // Configuration B: drain mode, 8-cycle timeout, 4-bit saturating counters.
  axis_gate_mc #(
    .C_NUM_CHANNELS(NCH), .C_AXIS_TDATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW),
    .C_AXIS_HAS_TLAST(1), .C_DRAIN_MODE(1), .C_TIMEOUT_CYCLES(TMO_B), .C_CNT_WIDTH(CW_B)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .shutdown_req(req), .shutdown_ack(ack_b),
    .timeout_flag(flag_b), .cnt_clear(cnt_clear), .discard_cnt(cnt_b),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b),
    .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tuser(m_tuser_b),
    .m_axis_tlast(m_tlast_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready)
  );

  typedef struct {
    int              st;
    bit              in_pkt;
    int              waited;
    bit              ack;
    bit              flag;
    longint unsigned cnt;
  } lane_m_t;

  lane_m_t         mdl [2][NCH];
  int              drain_cfg [2] = '{0, 1};
  int              tmo_cfg   [2] = '{0, TMO_B};
  longint unsigned cmax      [2] = '{64'hFFFF_FFFF, 64'd15};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_d = 0;
  int cur_l = 0;
  int n_timeout = 0;
  int n_sat     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d lane=%0d cyc=%0d got=%0h exp=%0h", tag, cur_d, cur_l, cyc, got, exp);
    end
  endtask

  function automatic bit is_open(input int st);
    return (st == G_PASS) || (st == G_WAIT);
  endfunction

  function automatic bit exp_ready(input int d, input int l);
    if (is_open(mdl[d][l].st)) return m_tready[l];
    if (mdl[d][l].st == G_SHUT) return drain_cfg[d] != 0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NCH; l++)
        mdl[d][l] = '{st: G_PASS, in_pkt: 1'b0, waited: 0, ack: 1'b0, flag: 1'b0, cnt: 0};
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    lane_m_t m, n;
    bit acc, eop, pkt_n, r;
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < NCH; l++) begin
        m     = mdl[d][l];
        n     = m;
        r     = req[l];
        acc   = s_tvalid[l] && exp_ready(d, l);
        eop   = acc && s_tlast[l];
        pkt_n = acc ? !s_tlast[l] : m.in_pkt;
        n.in_pkt = pkt_n;
        n.ack    = (m.st == G_SHUT);
        if (cnt_clear) n.cnt = 0;
        else if (acc && !is_open(m.st) && m.cnt < cmax[d]) n.cnt = m.cnt + 1;
        case (m.st)
          G_PASS: if (r) begin
            n.st     = pkt_n ? G_WAIT : G_SHUT;
            n.waited = 0;
          end
          G_WAIT: begin
            if (!r) n.st = G_PASS;
            else if (eop) n.st = G_SHUT;
            else if (tmo_cfg[d] > 0 && m.waited == tmo_cfg[d] - 1) begin
              n.st   = G_SHUT;
              n.flag = 1'b1;
              n_timeout++;
            end else n.waited = m.waited + 1;
          end
          G_SHUT: if (!r) n.st = pkt_n ? G_RESYNC : G_PASS;
          default: begin
            if (r) n.st = G_SHUT;
            else if (eop) n.st = G_PASS;
          end
        endcase
        if (!r) n.flag = 1'b0;
        if (n.cnt == cmax[d] && m.cnt != cmax[d] && d == 1) n_sat++;
        mdl[d][l] = n;
      end
    end
  endtask

  task automatic check_all();
    bit open;
    logic [63:0] g_rdy, g_vld, g_dat, g_kep, g_usr, g_lst, g_ack, g_flg, g_cnt;
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < NCH; l++) begin
        cur_d = d;
        cur_l = l;
        open  = is_open(mdl[d][l].st);
        g_rdy = 64'(d ? s_tready_b[l] : s_tready_a[l]);
        g_vld = 64'(d ? m_tvalid_b[l] : m_tvalid_a[l]);
        g_dat = 64'(d ? m_tdata_b[l*DW +: DW] : m_tdata_a[l*DW +: DW]);
        g_kep = 64'(d ? m_tkeep_b[l*KW +: KW] : m_tkeep_a[l*KW +: KW]);
        g_usr = 64'(d ? m_tuser_b[l*UW +: UW] : m_tuser_a[l*UW +: UW]);
        g_lst = 64'(d ? m_tlast_b[l] : m_tlast_a[l]);
        g_ack = 64'(d ? ack_b[l] : ack_a[l]);
        g_flg = 64'(d ? flag_b[l] : flag_a[l]);
        g_cnt = d ? 64'(cnt_b[l*CW_B +: CW_B]) : 64'(cnt_a[l*CW_A +: CW_A]);
        check_eq("s_tready", g_rdy, 64'(exp_ready(d, l)));
        check_eq("m_tvalid", g_vld, open ? 64'(s_tvalid[l]) : 64'd0);
        check_eq("m_tdata",  g_dat, open ? 64'(s_tdata[l*DW +: DW]) : 64'd0);
        check_eq("m_tkeep",  g_kep, open ? 64'(s_tkeep[l*KW +: KW]) : 64'd0);
        check_eq("m_tuser",  g_usr, open ? 64'(s_tuser[l*UW +: UW]) : 64'd0);
        check_eq("m_tlast",  g_lst, open ? 64'(s_tlast[l]) : 64'd0);
        check_eq("ack",      g_ack, 64'(mdl[d][l].ack));
        check_eq("tmo_flag", g_flg, 64'(mdl[d][l].flag));
        check_eq("disc_cnt", g_cnt, 64'(mdl[d][l].cnt));
      end
    end
  endtask

  // Per-phase stimulus profile: tvalid %, tlast %, tready %, req on/off per mille, clear per mille.
  int pv [4] = '{70,  8, 90, 60};
  int pl [4] = '{25, 30, 20, 35};
  int pr [4] = '{80, 90, 70, 75};
  int pon[4] = '{20, 40, 100, 30};
  int pof[4] = '{30, 10,  5, 30};
  int pcl[4] = '{10, 10,  3, 10};

  initial begin
    int ph;
    rst_n     = 1'b0;
    req       = '0;
    cnt_clear = 1'b0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tuser   = '0;
    s_tlast   = '0;
    s_tvalid  = '0;
    m_tready  = '0;
    model_reset();

    for (cyc = 0; cyc < int'(NCYC); cyc++) begin
      @(negedge clk);
      ph    = cyc / 500;
      rst_n = !((cyc < 3) || (cyc >= 1700 && cyc < 1703));
      for (int l = 0; l < NCH; l++) begin
        if ($urandom_range(999) < 32'(req[l] ? pof[ph] : pon[ph])) req[l] = ~req[l];
        s_tvalid[l] = $urandom_range(99) < 32'(pv[ph]);
        s_tlast[l]  = $urandom_range(99) < 32'(pl[ph]);
        m_tready[l] = $urandom_range(99) < 32'(pr[ph]);
      end
      s_tdata   = {$urandom, $urandom};
      s_tkeep   = 8'($urandom);
      s_tuser   = 4'($urandom);
      cnt_clear = $urandom_range(999) < 32'(pcl[ph]);
      #1;
      if (!rst_n) model_reset();
      check_all();
      if (rst_n) model_step();
    end

    // Forced shutdowns and counter saturation must actually have been exercised.
    cur_d = 1;
    cur_l = 0;
    check_eq("timeouts_seen", 64'(n_timeout > 0), 64'd1);
    check_eq("saturation_seen", 64'(n_sat > 0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
